// File: rtl/led_sequencer_ctrl.sv
// Command-driven LED sequencer: accepts one command (IDLE only), then updates LED once per prescaler tick.
// First update P cycles after the first RUN cycle; cmd_ready is low outside IDLE so the source holds its command.
module led_sequencer_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 32,
  parameter int STEPW = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [CNTW-1:0]  cmd_period,
  input  logic [STEPW-1:0] cmd_steps,
  input  logic [WIDTH-1:0] cmd_init,
  input  logic             abort,
  output logic [WIDTH-1:0] LED,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MODE_COUNT = 2'd0;
  localparam logic [1:0] MODE_SHIFT = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNTW-1:0]  period_q, period_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [STEPW-1:0] steps_q, steps_d;
  logic [STEPW-1:0] step_cnt_q, step_cnt_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] led_next;
  logic             wrap;
  logic             last_step;

  assign wrap      = (count_q == period_q - CNTW'(1));
  assign last_step = (steps_q != '0) && (step_cnt_q + STEPW'(1) == steps_q);

  always_comb begin
    led_next = led_q;
    unique case (mode_q)
      MODE_COUNT: led_next = led_q + WIDTH'(1);
      // An all-zero pattern has nothing to rotate, so seed it with bit 0.
      MODE_SHIFT: led_next = (led_q == '0) ? WIDTH'(1) : {led_q[WIDTH-2:0], led_q[WIDTH-1]};
      MODE_BLINK: led_next = ~led_q;
      default:    led_next = led_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    period_d   = period_q;
    count_d    = count_q;
    steps_d    = steps_q;
    step_cnt_d = step_cnt_q;
    led_d      = led_q;
    tick_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          mode_d     = cmd_mode;
          period_d   = (cmd_period == '0) ? CNTW'(1) : cmd_period;
          steps_d    = cmd_steps;
          led_d      = cmd_init;
          count_d    = '0;
          step_cnt_d = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort takes priority over a tick landing on the same edge.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (wrap) begin
          count_d    = '0;
          tick_d     = 1'b1;
          led_d      = led_next;
          step_cnt_d = step_cnt_q + STEPW'(1);
          if (last_step) begin
            state_d = ST_DONE;
          end
        end else begin
          count_d = count_q + CNTW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_COUNT;
      period_q   <= CNTW'(1);
      count_q    <= '0;
      steps_q    <= '0;
      step_cnt_q <= '0;
      led_q      <= '0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      period_q   <= period_d;
      count_q    <= count_d;
      steps_q    <= steps_d;
      step_cnt_q <= step_cnt_d;
      led_q      <= led_d;
      tick_q     <= tick_d;
    end
  end

  assign LED       = led_q;
  assign tick      = tick_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign cmd_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_led_sequencer_ctrl.sv
// Randomized bench for led_sequencer_ctrl against an elapsed-time reference model.
module tb_led_sequencer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic [31:0] cmd_period;
  logic [15:0] cmd_steps;
  logic [7:0]  cmd_init;
  logic        abort;
  logic [7:0]  led;
  logic        tick;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  led_sequencer_ctrl #(.WIDTH(8), .CNTW(32), .STEPW(16)) dut (
    .CLK(clk), .RST(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_period(cmd_period), .cmd_steps(cmd_steps), .cmd_init(cmd_init),
    .abort(abort), .LED(led), .tick(tick), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  // Model: position in a run is just the number of edges since acceptance.
  int m_phase = M_IDLE;
  int m_t = 0;
  int m_mode = 0;
  int m_p = 1;
  int m_steps = 0;
  int m_init = 0;
  int m_led = 0;
  int m_tick = 0;
  int m_accepts = 0;

  // LED value after k ticks, straight from the mode rules.
  function automatic int led_after(int mode, int init, int k);
    int v;
    int r;
    case (mode)
      0: return (init + k) & 255;
      1: begin
        if (init == 0) begin
          if (k == 0) return 0;
          v = 1;
          r = (k - 1) % 8;
        end else begin
          v = init;
          r = k % 8;
        end
        return ((v << r) | (v >> (8 - r))) & 255;
      end
      2: return (k % 2 == 1) ? (~init & 255) : init;
      default: return init;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int k;
    if (rst) begin
      m_phase = M_IDLE;
      m_led = 0;
      m_tick = 0;
    end else begin
      case (m_phase)
        M_IDLE: begin
          m_tick = 0;
          if (cmd_valid) begin
            m_phase = M_RUN;
            m_t = 0;
            m_mode = int'(cmd_mode);
            m_p = (cmd_period == 0) ? 1 : int'(cmd_period);
            m_steps = int'(cmd_steps);
            m_init = int'(cmd_init);
            m_led = int'(cmd_init);
            m_accepts++;
          end
        end
        M_RUN: begin
          if (abort) begin
            m_phase = M_IDLE;
            m_tick = 0;
          end else begin
            m_t++;
            m_tick = (m_t % m_p == 0) ? 1 : 0;
            if (m_tick == 1) begin
              k = m_t / m_p;
              m_led = led_after(m_mode, m_init, k);
              if (m_steps != 0 && k == m_steps) m_phase = M_DONE;
            end
          end
        end
        default: begin
          m_phase = M_IDLE;
          m_tick = 0;
        end
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("led", 32'(led), 32'(m_led));
    check("tick", 32'(tick), 32'(m_tick));
    check("busy", 32'(busy), (m_phase == M_RUN) ? 32'd1 : 32'd0);
    check("done", 32'(done), (m_phase == M_DONE) ? 32'd1 : 32'd0);
    check("cmd_ready", 32'(cmd_ready), (m_phase == M_IDLE) ? 32'd1 : 32'd0);
  endtask

  task automatic drive_cmd(input int mode, input int p, input int steps, input int init);
    cmd_mode = 2'(mode);
    cmd_period = 32'(p);
    cmd_steps = 16'(steps);
    cmd_init = 8'(init);
    cmd_valid = 1'b1;
  endtask

  // abort_at: edge index (since acceptance) at which abort is sampled; 0 = never.
  task automatic run_cmd(input int mode, input int p, input int steps, input int init, input int abort_at);
    int n0;
    int budget;
    n0 = m_accepts;
    drive_cmd(mode, p, steps, init);
    budget = 0;
    while (m_accepts == n0 && budget < 20) begin
      abort = 1'($urandom % 2);
      cycle();
      budget++;
    end
    cmd_valid = 1'b0;
    budget = 0;
    while (m_phase != M_IDLE && budget < 2000) begin
      abort = (abort_at != 0 && m_phase == M_RUN && m_t + 1 == abort_at) ? 1'b1 : 1'b0;
      cycle();
      budget++;
    end
    abort = 1'b0;
    check("run_ends", (m_phase == M_IDLE) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int n0;
    int budget;
    int mode, p, steps, init, abort_at;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode = '0;
    cmd_period = '0;
    cmd_steps = '0;
    cmd_init = '0;
    abort = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    run_cmd(0, 4, 3, 8'h00, 0);
    cycle();
    run_cmd(1, 1, 9, 8'h00, 0);
    run_cmd(0, 0, 2, 8'hFF, 0);
    run_cmd(2, 3, 0, 8'hA5, 12);
    cycle();

    // Second command held on the bus throughout the first run.
    n0 = m_accepts;
    drive_cmd(0, 2, 2, 8'h10);
    budget = 0;
    while (m_accepts == n0 && budget < 20) begin cycle(); budget++; end
    drive_cmd(2, 1, 3, 8'h3C);
    budget = 0;
    while (m_accepts == n0 + 1 && budget < 50) begin cycle(); budget++; end
    cmd_valid = 1'b0;
    budget = 0;
    while (m_phase != M_IDLE && budget < 50) begin cycle(); budget++; end
    check("held_cmd_ends", (m_phase == M_IDLE) ? 32'd1 : 32'd0, 32'd1);

    // Reset in the middle of a HOLD run.
    n0 = m_accepts;
    drive_cmd(3, 5, 0, 8'h77);
    budget = 0;
    while (m_accepts == n0 && budget < 20) begin cycle(); budget++; end
    cmd_valid = 1'b0;
    repeat (7) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (3) cycle();

    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 3));
      p = int'($urandom_range(0, 5));
      steps = int'($urandom_range(0, 6));
      init = int'($urandom_range(0, 255));
      if (i % 5 == 0) init = 0;
      if (steps == 0) abort_at = int'($urandom_range(1, 40));
      else if ($urandom % 3 == 0) abort_at = int'($urandom_range(1, steps * ((p == 0) ? 1 : p)));
      else abort_at = 0;
      run_cmd(mode, p, steps, init, abort_at);
      repeat ($urandom_range(0, 2)) begin
        abort = 1'($urandom % 2);
        cycle();
      end
      abort = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
